// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for a bank of common-anode
// seven-segment digits. Each digit slot is a blanking gap followed by a
// lit dwell; display data is swapped in only at frame boundaries so one
// frame never mixes two updates. All outputs are registered.
module seg7_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     mask,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  load_ack,
    output logic                  frame_sync
);

    // One counter serves both phases, so it must hold the larger terminal count.
    localparam int CMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    // Sequential state
    phase_t                r_phase;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [7*DIGITS-1:0]   r_frame;
    logic [DIGITS-1:0]     r_mask;
    logic                  r_pending;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_load_ack;
    logic                  r_frame_sync;

    // Next-state decode
    phase_t                w_phase_next;
    logic [CW-1:0]         w_cnt_next;
    logic [IW-1:0]         w_idx_next;
    logic                  w_boundary;
    logic                  w_capture;
    logic [7*DIGITS-1:0]   w_frame_next;
    logic [DIGITS-1:0]     w_mask_next;
    logic                  w_pending_next;
    logic                  w_lit;
    logic [6:0]            w_seg_next;
    logic [DIGITS-1:0]     w_an_next;
    logic [6:0]            w_digit_pat [DIGITS];

    // Phase/counter/index sequencing and frame-boundary capture decision
    always_comb begin
        w_phase_next = r_phase;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_boundary   = 1'b0;
        if (r_phase == PH_BLANK) begin
            if (r_cnt == BLANK_LAST) begin
                w_phase_next = PH_SHOW;
                w_cnt_next   = '0;
                w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                // Entering digit 0 marks the start of a frame; with one digit
                // every blank-to-show edge qualifies.
                w_boundary   = (w_idx_next == '0);
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end else begin
            if (r_cnt == DWELL_LAST) begin
                w_phase_next = PH_BLANK;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end

        // A load on the boundary edge itself is captured immediately;
        // any other load is remembered until the next boundary.
        w_capture      = w_boundary && (r_pending || load);
        w_frame_next   = w_capture ? din  : r_frame;
        w_mask_next    = w_capture ? mask : r_mask;
        w_pending_next = w_boundary ? 1'b0 : (r_pending || load);

        // Outputs are computed from the next state so they change on the
        // same edge as phase/idx, and fresh data shows alongside load_ack.
        w_lit      = (w_phase_next == PH_SHOW) && w_mask_next[w_idx_next];
        w_seg_next = w_lit ? w_digit_pat[w_idx_next] : 7'd0;
    end

    // Per-digit pattern slices and one-cold anode decode
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_digit_pat[gi] = w_frame_next[7*gi +: 7];
            assign w_an_next[gi]   = !(w_lit && (w_idx_next == IW'(gi)));
        end
    endgenerate

    // Scan FSM state and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase      <= PH_BLANK;
            r_cnt        <= '0;
            r_idx        <= IDX_LAST;
            r_frame      <= '0;
            r_mask       <= '0;
            r_pending    <= 1'b0;
            r_seg        <= 7'd0;
            r_an         <= '1;
            r_load_ack   <= 1'b0;
            r_frame_sync <= 1'b0;
        end else begin
            r_phase      <= w_phase_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_frame      <= w_frame_next;
            r_mask       <= w_mask_next;
            r_pending    <= w_pending_next;
            r_seg        <= w_seg_next;
            r_an         <= w_an_next;
            r_load_ack   <= w_capture;
            r_frame_sync <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign load_ack   = r_load_ack;
    assign frame_sync = r_frame_sync;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Testbench for seg7_scan_mux: a 4-digit and a 1-digit instance run side by
// side against a timeline model that derives slot, digit and boundary from
// the number of edges since reset release.
module tb_seg7_scan_mux;

    localparam int DW = 4;
    localparam int BL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, load4;
    logic [27:0] din4;
    logic [3:0]  mask4;
    logic [6:0]  seg4;
    logic [3:0]  an4;
    logic        ack4, sync4;

    logic        rst1, load1;
    logic [6:0]  din1;
    logic [0:0]  mask1;
    logic [6:0]  seg1;
    logic [0:0]  an1;
    logic        ack1, sync1;

    seg7_scan_mux #(.DIGITS(4), .DWELL(DW), .BLANK_CYC(BL)) dut4 (
        .clk(clk), .reset(rst4), .din(din4), .mask(mask4), .load(load4),
        .seg(seg4), .an(an4), .load_ack(ack4), .frame_sync(sync4)
    );

    seg7_scan_mux #(.DIGITS(1), .DWELL(DW), .BLANK_CYC(BL)) dut1 (
        .clk(clk), .reset(rst1), .din(din1), .mask(mask1), .load(load1),
        .seg(seg1), .an(an1), .load_ack(ack1), .frame_sync(sync1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ack_count4 = 0;

    // Reference model state, index 0 = 4-digit instance, 1 = 1-digit instance
    int         mt     [2];
    bit         mv     [2];
    bit         mpend  [2];
    logic [6:0] mframe [2][4];
    logic [3:0] mmask  [2];
    logic       e_ack  [2];
    logic       e_sync [2];
    logic [6:0] e_seg  [2];
    logic [3:0] e_an   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input int k, input logic rst, input logic ld,
                              input logic [27:0] d, input logic [3:0] mk);
        int nd, per, u, slot;
        bit bnd;
        nd  = (k == 0) ? 4 : 1;
        per = nd * (DW + BL);
        e_ack[k]  = 1'b0;
        e_sync[k] = 1'b0;
        if (!rst) begin
            mv[k]    = 1'b1;
            mt[k]    = 0;
            mpend[k] = 1'b0;
            mmask[k] = 4'd0;
            for (int i = 0; i < 4; i++) mframe[k][i] = 7'd0;
        end else begin
            mt[k]++;
            bnd = (mt[k] >= BL) && (((mt[k] - BL) % per) == 0);
            if (bnd) begin
                e_sync[k] = 1'b1;
                if (mpend[k] || ld) begin
                    for (int i = 0; i < nd; i++) mframe[k][i] = d[7*i +: 7];
                    mmask[k] = mk;
                    mpend[k] = 1'b0;
                    e_ack[k] = 1'b1;
                end
            end else if (ld) begin
                mpend[k] = 1'b1;
            end
        end
        e_an[k]  = 4'((1 << nd) - 1);
        e_seg[k] = 7'd0;
        if (mt[k] >= BL) begin
            u    = (mt[k] - BL) % per;
            slot = u / (DW + BL);
            if (((u % (DW + BL)) < DW) && mmask[k][slot]) begin
                e_an[k][slot] = 1'b0;
                e_seg[k]      = mframe[k][slot];
            end
        end
    endtask

    // One clock: update the model at the edge, then compare just after it.
    task automatic step();
        @(posedge clk);
        model_edge(0, rst4, load4, din4, mask4);
        model_edge(1, rst1, load1, {21'd0, din1}, {3'd0, mask1});
        #1;
        if (mv[0]) begin
            check("seg4", 32'(seg4), 32'(e_seg[0]));
            check("an4", 32'(an4), 32'(e_an[0]));
            check("load_ack4", 32'(ack4), 32'(e_ack[0]));
            check("frame_sync4", 32'(sync4), 32'(e_sync[0]));
        end
        if (mv[1]) begin
            check("seg1", 32'(seg1), 32'(e_seg[1]));
            check("an1", 32'({3'd0, an1}), 32'(e_an[1]));
            check("load_ack1", 32'(ack1), 32'(e_ack[1]));
            check("frame_sync1", 32'(sync1), 32'(e_sync[1]));
        end
        if (ack4) ack_count4++;
    endtask

    // Step until the selected condition holds; 0=frame_sync, 1=load_ack, 2=an==1101.
    task automatic wait_for(input int which, input int max_cyc, input string tag);
        bit found;
        found = 1'b0;
        for (int n = 0; n < max_cyc && !found; n++) begin
            step();
            case (which)
                0:       found = sync4;
                1:       found = ack4;
                default: found = (an4 == 4'b1101);
            endcase
        end
        if (!found) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        mv[0] = 1'b0; mv[1] = 1'b0;
        rst4 = 1'b0; load4 = 1'b0; din4 = 28'd0; mask4 = 4'd0;
        rst1 = 1'b0; load1 = 1'b0; din1 = 7'd0;  mask1 = 1'b0;

        // Reset held for three cycles, then idle with an empty mask
        repeat (3) step();
        rst4 = 1'b1; rst1 = 1'b1;
        load1 = 1'b1; din1 = 7'($urandom); mask1 = 1'b1;
        step();
        load1 = 1'b0;
        repeat (49) step();
        check("idle_an_blank", 32'(an4), 32'hF);

        // Basic display with all digits enabled
        din4  = {7'h66, 7'h4F, 7'h5B, 7'h06};
        mask4 = 4'b1111;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        wait_for(1, 40, "basic_ack_timeout");
        check("basic_sync_with_ack", 32'(sync4), 32'd1);
        check("basic_an_digit0", 32'(an4), 32'b1110);
        check("basic_seg_digit0", 32'(seg4), 32'h06);
        repeat (48) step();

        // Masked digits 1 and 3
        mask4 = 4'b0101;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        wait_for(1, 40, "mask_ack_timeout");
        repeat (48) step();

        // Three loads inside one frame collapse to a single capture
        wait_for(0, 40, "collapse_sync_timeout");
        repeat (3) step();
        ack_count4 = 0;
        load4 = 1'b1; step(); load4 = 1'b0; step(); step();
        load4 = 1'b1; step(); load4 = 1'b0; step();
        load4 = 1'b1; step(); load4 = 1'b0;
        din4[6:0] = 7'h7F;
        repeat (20) step();
        check("collapse_one_ack", 32'(ack_count4), 32'd1);

        // Load presented exactly on the boundary edge
        wait_for(0, 40, "coinc_sync_timeout");
        repeat (23) step();
        din4  = 28'($urandom);
        mask4 = 4'b1111;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        check("coinc_ack", 32'(ack4), 32'd1);
        check("coinc_sync", 32'(sync4), 32'd1);

        // Randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            load4 = ($urandom_range(0, 15) == 0);
            load1 = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) din4 = 28'($urandom);
            if ($urandom_range(0, 7) == 0) din1 = 7'($urandom);
            mask4 = 4'($urandom);
            mask1 = 1'($urandom);
            step();
        end
        load4 = 1'b0; load1 = 1'b0;

        // Make every digit visible before the mid-scan reset
        mask4 = 4'b1111;
        din4  = 28'($urandom);
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        wait_for(1, 40, "preload_ack_timeout");

        // Reset while digit 1 is lit and a load is pending
        wait_for(2, 60, "digit1_lit_timeout");
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        rst4 = 1'b0;
        step();
        rst4 = 1'b1;
        check("midreset_an", 32'(an4), 32'hF);
        check("midreset_seg", 32'(seg4), 32'd0);
        ack_count4 = 0;
        repeat (60) step();
        check("midreset_no_ack", 32'(ack_count4), 32'd0);
        check("midreset_still_blank", 32'(an4), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed driver for a bank of common-anode seven-segment digits. It consumes the 7-bit segment patterns produced by the counter/decoder stage (one pattern per digit, segments active-high) and drives a shared segment bus plus per-digit anode enables. Each digit is lit in turn for a fixed dwell, with a blanking gap between digits to suppress ghosting. New display data is latched only at frame boundaries, so a frame never shows digits from two different updates.

## Interface
- DIGITS, 4: number of digits scanned, legal range 1..8
- DWELL, 1000: cycles each digit is lit, ≥1
- BLANK_CYC, 16: cycles of all-off between digits, ≥1

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- din  in  7*DIGITS  segment patterns; digit i is din[7i+6:7i]; bit 0 = segment a; active-high
- mask  in  DIGITS  digit enable; bit i = 1 shows digit i
- load  in  1  request to latch din/mask at the next frame boundary
- seg  out  7  segment bus, active-high, registered
- an  out  DIGITS  anode enables, active-low (one-cold), registered
- load_ack  out  1  one-cycle pulse: din/mask have been latched
- frame_sync  out  1  one-cycle pulse: first lit cycle of digit 0

## Operation
- Internal state: phase ∈ {BLANK, SHOW}, digit index idx (0..DIGITS-1), dwell counter cnt, frame register (7*DIGITS), mask register (DIGITS), pending flag.
- Reset values: phase=BLANK, cnt=0, idx=DIGITS-1, frame=0, mask register=0, pending=0, seg=0, an=all ones, load_ack=0, frame_sync=0.
- BLANK: an=all ones, seg=0. It lasts BLANK_CYC cycles. On the edge where cnt==BLANK_CYC-1: phase←SHOW, cnt←0, idx←(idx+1) mod DIGITS.
- SHOW: if mask register[idx]=1, then an[idx]=0, the other anodes are 1, and seg=frame[idx]. Otherwise an=all ones and seg=0; the slot still consumes full time. It lasts DWELL cycles. On the edge where cnt==DWELL-1: phase←BLANK, cnt←0.
- Frame boundary: the BLANK→SHOW edge where idx wraps to 0. On that edge:
  - frame_sync←1 for one cycle.
  - If pending=1, or load=1 on that same edge, din and mask are sampled into the registers, pending←0, and load_ack←1 for one cycle.
- load=1 on any other edge sets pending. Multiple loads before a boundary collapse into one capture and one load_ack.
- din and mask are sampled only at the capture edge, not at the load edge. The upstream stage holds din stable from load until load_ack.
- The new frame's data is visible in the same cycle load_ack is high, because the registers update together.
- DIGITS=1: idx is always 0, and every BLANK→SHOW edge is a frame boundary.
- No combinational path from any input to any output.

## Timing
- All outputs are flops updated on the same edge as phase/idx.
- Frame period = DIGITS*(DWELL+BLANK_CYC) cycles. frame_sync recurs at exactly this period.
- First frame boundary: the BLANK_CYC-th rising edge with reset=1 after release.
- Load latency: from a load edge to load_ack is at most one frame period plus one cycle. It is 0 extra cycles if load coincides with the boundary edge.
- Reset mid-operation: the next edge with reset=0 restores all reset values and discards pending, regardless of phase. No load_ack is issued for a request that reset discarded.
- Counter widths hold max(DWELL, BLANK_CYC)-1 and DIGITS-1 without overflow. idx wraps modulo DIGITS for non-power-of-two DIGITS.

## Test plan
Test parameters: DIGITS=4, DWELL=4, BLANK_CYC=2 (frame period 24).

- Reset: hold reset=0 for 3 cycles, then release with load=0 → seg=0, an=4'b1111, load_ack=0 throughout. frame_sync pulses on the 2nd edge after release and every 24 cycles thereafter. an stays 4'b1111 because the mask register is 0.
- Basic display: din={7'h66,7'h4F,7'h5B,7'h06} (digit3..digit0), mask=4'b1111, one-cycle load → load_ack and frame_sync are high together. The sequence is:
  - an=4'b1110 / seg=7'h06 for 4 cycles, then an=4'b1111 / seg=0 for 2 cycles;
  - an=4'b1101 / seg=7'h5B for 4 cycles, 2 blank cycles;
  - an=4'b1011 / seg=7'h4F, 2 blank cycles;
  - an=4'b0111 / seg=7'h66, 2 blank cycles; then repeat.
- Masking: load with mask=4'b0101 → digits 1 and 3 show an=4'b1111 and seg=0 for their 4-cycle slots. Timing is unchanged and frame_sync period stays 24.
- Pending collapse and coincidence:
  - Pulse load three times mid-frame, changing din to 7'h7F in digit 0 before the boundary → exactly one load_ack, and digit 0 shows 7'h7F.
  - load asserted only on the boundary edge → captured on that edge, with load_ack in the same cycle as frame_sync.
- Reset mid-SHOW: assert reset=0 for one cycle while an=4'b1101, with a load pending → next cycle an=4'b1111 and seg=0. No load_ack follows, and the display stays blank until a new load.
- DIGITS=1 build (DWELL=4, BLANK_CYC=2): frame_sync every 6 cycles, an alternates 1'b0 (4 cycles) and 1'b1 (2 cycles).
